shunting_yard: RTL and testbench
================================

SHUNTING_YARD -- requirements
Module: shunting_yard

Interface
REQ-001 Parameter: STACK_DEPTH, 16, operator-stack entries (power of two, 4..64).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 IN_TOKEN  input  8  infix token: unsigned number, or ASCII '+', '-', '*', '/', '(', ')'.
REQ-005 IN_IS_NUM  input  1  IN_TOKEN is a number when high.
REQ-006 IN_LAST  input  1  token is the final token of the expression.
REQ-007 IN_STB  input  1  token valid; accepted on a cycle with IN_STB and IN_READY both high.
REQ-008 IN_READY  output  1  block can accept a token this cycle.
REQ-009 DOWN_BUSY  input  1  downstream evaluator BUSY.
REQ-010 OUT_NUMBER  output  8  postfix number, valid with NUMBER_STB.
REQ-011 OUT_SIGN  output  8  postfix operator (ASCII), valid with SIGN_STB.
REQ-012 NUMBER_STB, SIGN_STB  output  1 each  one-cycle emit strobes; both high together mark end of expression.
REQ-013 ERROR  output  1  sticky protocol/syntax error flag.

Function
REQ-014 States SHALL be ACCEPT, POP_PREC, POP_PAREN, DRAIN, FINISH, ERR.
REQ-015 IN_READY SHALL be high only in ACCEPT with no emission pending.
REQ-016 Emission rule: a strobe SHALL assert only if DOWN_BUSY was low the previous cycle and no strobe asserted the previous cycle (at least one idle cycle between strobes).
REQ-017 Number accepted at cycle N: NUMBER_STB at N+1 earliest, OUT_NUMBER = IN_TOKEN, stalled by REQ-016.
REQ-018 Precedence: '*','/' = 2; '+','-' = 1; '(' = 0; all operators left-associative.
REQ-019 Operator accepted: go to POP_PREC, pop and emit (SIGN_STB) while top precedence >= incoming, then push incoming, return to ACCEPT.
REQ-020 '(' SHALL be pushed directly; ')' enters POP_PAREN, emitting pops until '(' is found, which is discarded without emission.
REQ-021 After accepting the IN_LAST token: DRAIN pops and emits every stacked operator except the bottom one; FINISH then asserts NUMBER_STB and SIGN_STB in the same cycle with OUT_SIGN = bottom operator, OUT_NUMBER = 0.
REQ-022 Empty stack at FINISH (single-number expression): combined strobe with OUT_SIGN = 8'h00.
REQ-023 After FINISH: stack empty, return to ACCEPT for the next expression.
REQ-024 Errors enter ERR and set ERROR: push when full; ')' with no '(' on the stack; '(' remaining in DRAIN; non-number token not in REQ-004 set; IN_LAST token that is an operator other than ')'.
REQ-025 ERR: IN_READY low, no strobes; exits only via RST.
REQ-026 Simultaneous operator push and pop never occurs; each cycle does at most one stack operation.

Reset
REQ-027 On RST: state ACCEPT, stack pointer 0, IN_READY 0 during the reset cycle and 1 the cycle after, all strobes 0, OUT_NUMBER/OUT_SIGN 0, ERROR 0.
REQ-028 RST mid-expression SHALL discard stack and any pending emission with no further strobe.

Configuration
REQ-029 Macro SHUNTING_YARD_PAREN_EN: defined -> '(' and ')' handled per REQ-020; undefined -> both are illegal tokens (REQ-024), and POP_PAREN state and its logic are absent.

Structure
REQ-030 Package shunting_yard_pkg SHALL hold the state enum, ASCII token constants, and the precedence function.
REQ-031 Sub-module op_stack: synchronous LIFO (push, pop, top, empty, full), width 8, depth STACK_DEPTH.

Verification
REQ-032 "3 + 4" (last on 4), DOWN_BUSY low -> NUMBER_STB 3, NUMBER_STB 4, then combined strobe OUT_SIGN '+'.
REQ-033 "2 + 3 * 4" -> 2, 3, 4, SIGN '*', combined '+'.
REQ-034 "(1 + 2) * 3" with PAREN_EN -> 1, 2, SIGN '+', 3, combined '*'; without PAREN_EN -> ERROR=1 after the '(' token.
REQ-035 "8 - 2 - 1" with DOWN_BUSY held high 5 cycles after the first strobe -> no strobe while high; order 8, 2, SIGN '-', 1, combined '-'; strobes always separated by at least 1 idle cycle.
REQ-036 17 consecutive '(' tokens (STACK_DEPTH 16) -> ERROR=1 on the 17th; RST -> ERROR=0, IN_READY=1.
REQ-037 Single token 5 with IN_LAST -> NUMBER_STB 5, then combined strobe with OUT_SIGN 8'h00.

Source files
------------

// File: rtl/shunting_yard_pkg.sv
// Shared definitions for the shunting_yard infix-to-postfix converter:
// FSM state encodings, ASCII token codes, emission kinds and operator helpers.
package shunting_yard_pkg;

    // FSM states (kept as plain constants so legacy tools can consume them)
    typedef logic [2:0] state_t;
    localparam state_t ST_ACCEPT    = 3'd0;
    localparam state_t ST_POP_PREC  = 3'd1;
    localparam state_t ST_POP_PAREN = 3'd2;
    localparam state_t ST_DRAIN     = 3'd3;
    localparam state_t ST_FINISH    = 3'd4;
    localparam state_t ST_ERR       = 3'd5;

    // ASCII token codes
    localparam logic [7:0] TOK_ADD    = 8'h2B;  // '+'
    localparam logic [7:0] TOK_SUB    = 8'h2D;  // '-'
    localparam logic [7:0] TOK_MUL    = 8'h2A;  // '*'
    localparam logic [7:0] TOK_DIV    = 8'h2F;  // '/'
    localparam logic [7:0] TOK_LPAREN = 8'h28;  // '('
    localparam logic [7:0] TOK_RPAREN = 8'h29;  // ')'

    // Emission kinds: bit 0 drives number_stb, bit 1 drives sign_stb
    typedef logic [1:0] emit_t;
    localparam emit_t EMIT_NUM  = 2'b01;
    localparam emit_t EMIT_SIGN = 2'b10;
    localparam emit_t EMIT_BOTH = 2'b11;

    // Binding strength; '(' ranks lowest so it stops every precedence pop
    function automatic logic [1:0] prec(input logic [7:0] op);
        case (op)
            TOK_MUL, TOK_DIV: prec = 2'd2;
            TOK_ADD, TOK_SUB: prec = 2'd1;
            default:          prec = 2'd0;
        endcase
    endfunction

    function automatic logic is_arith(input logic [7:0] tok);
        is_arith = (tok == TOK_ADD) || (tok == TOK_SUB) ||
                   (tok == TOK_MUL) || (tok == TOK_DIV);
    endfunction

endpackage

// File: rtl/shunting_yard_op_stack.sv
// op_stack: synchronous 8-bit LIFO holding pending operators.
// Push into a full stack and pop from an empty stack are ignored.
module op_stack #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               data,
    output logic [7:0]               top,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] sp;
    logic [AW:0] sp_m1;

    assign sp_m1 = sp - 1'b1;
    assign empty = (sp == '0);
    assign full  = (sp == (AW+1)'(DEPTH));
    assign count = sp;
    assign top   = empty ? 8'h00 : mem[sp_m1[AW-1:0]];

    // Stack pointer moves by one per push or pop
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst)
            sp <= '0;
        else if (push && !full)
            sp <= sp + 1'b1;
        else if (pop && !empty)
            sp <= sp_m1;
    end

    // Operator storage written at the current pointer on push
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; entries above sp are never read.
        if (push && !full)
            mem[sp[AW-1:0]] <= data;
    end

endmodule

// File: rtl/shunting_yard.sv
// shunting_yard: converts a stream of infix tokens into postfix emissions
// (numbers on number_stb, operators on sign_stb, both strobes together to
// close an expression). Parenthesis support is compiled in when the macro
// SHUNTING_YARD_PAREN_EN is defined; otherwise '(' and ')' are illegal tokens.
module shunting_yard
    import shunting_yard_pkg::*;
#(
    parameter int STACK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_token,
    input  logic       in_is_num,
    input  logic       in_last,
    input  logic       in_stb,
    output logic       in_ready,
    input  logic       down_busy,
    output logic [7:0] out_number,
    output logic [7:0] out_sign,
    output logic       number_stb,
    output logic       sign_stb,
    output logic       error
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;

    state_t     state, state_n;
    logic [7:0] cur_op, cur_op_n;
    logic       emit_pend, pend_n;
    emit_t      emit_kind, kind_n;
    logic [7:0] emit_val, val_n;
    logic       error_q, err_n;
    logic       busy_q, stb_q;
`ifdef SHUNTING_YARD_PAREN_EN
    logic       last_q, last_n;
`endif

    logic          push, pop;
    logic [7:0]    push_data, top;
    logic          empty, full;
    logic [CW-1:0] count;

    logic can_emit, emit_fire, accept;

    op_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .data  (push_data),
        .top   (top),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    // A strobe needs an idle, non-busy previous cycle
    assign can_emit   = !busy_q && !stb_q;
    assign emit_fire  = !rst && emit_pend && can_emit;
    assign number_stb = emit_fire && emit_kind[0];
    assign sign_stb   = emit_fire && emit_kind[1];
    assign out_number = (number_stb && !emit_kind[1]) ? emit_val : 8'h00;
    assign out_sign   = sign_stb ? emit_val : 8'h00;
    assign in_ready   = !rst && (state == ST_ACCEPT) && !emit_pend;
    assign accept     = in_stb && in_ready;
    assign error      = error_q;

    // Next-state, stack control and emission scheduling
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        state_n   = state;
        cur_op_n  = cur_op;
        pend_n    = emit_pend && !emit_fire;
        kind_n    = emit_kind;
        val_n     = emit_val;
        err_n     = error_q;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = cur_op;
`ifdef SHUNTING_YARD_PAREN_EN
        last_n    = last_q;
`endif
        case (state)
            ST_ACCEPT: if (accept) begin
                if (in_is_num) begin
                    pend_n = 1'b1;
                    kind_n = EMIT_NUM;
                    val_n  = in_token;
                    if (in_last) state_n = ST_DRAIN;
                end else if (is_arith(in_token) && !in_last) begin
                    cur_op_n = in_token;
                    state_n  = ST_POP_PREC;
`ifdef SHUNTING_YARD_PAREN_EN
                end else if (in_token == TOK_LPAREN && !in_last && !full) begin
                    push      = 1'b1;
                    push_data = in_token;
                end else if (in_token == TOK_RPAREN) begin
                    last_n  = in_last;
                    state_n = ST_POP_PAREN;
`endif
                end else begin
                    state_n = ST_ERR;
                end
            end
            ST_POP_PREC: if (!emit_pend) begin
                if (!empty && prec(top) >= prec(cur_op)) begin
                    pop    = 1'b1;
                    pend_n = 1'b1;
                    kind_n = EMIT_SIGN;
                    val_n  = top;
                end else if (full) begin
                    state_n = ST_ERR;
                end else begin
                    push    = 1'b1;
                    state_n = ST_ACCEPT;
                end
            end
`ifdef SHUNTING_YARD_PAREN_EN
            ST_POP_PAREN: if (!emit_pend) begin
                if (empty) begin
                    state_n = ST_ERR;
                end else if (top == TOK_LPAREN) begin
                    pop     = 1'b1;
                    state_n = last_q ? ST_DRAIN : ST_ACCEPT;
                end else begin
                    pop    = 1'b1;
                    pend_n = 1'b1;
                    kind_n = EMIT_SIGN;
                    val_n  = top;
                end
            end
`endif
            ST_DRAIN: if (!emit_pend) begin
                if (empty) begin
                    state_n = ST_FINISH;
                end else if (top == TOK_LPAREN) begin
                    state_n = ST_ERR;
                end else if (count == CW'(1)) begin
                    state_n = ST_FINISH;
                end else begin
                    pop    = 1'b1;
                    pend_n = 1'b1;
                    kind_n = EMIT_SIGN;
                    val_n  = top;
                end
            end
            ST_FINISH: if (!emit_pend) begin
                pop     = !empty;
                pend_n  = 1'b1;
                kind_n  = EMIT_BOTH;
                val_n   = top;
                state_n = ST_ACCEPT;
            end
            ST_ERR: ;
            default: state_n = ST_ERR;
        endcase
        if (state_n == ST_ERR) begin
            err_n  = 1'b1;
            pend_n = 1'b0;
        end
    end

    // Control registers, emission slot and strobe-spacing history
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACCEPT;
            cur_op    <= 8'h00;
            emit_pend <= 1'b0;
            emit_kind <= EMIT_NUM;
            emit_val  <= 8'h00;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            stb_q     <= 1'b0;
`ifdef SHUNTING_YARD_PAREN_EN
            last_q    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cur_op    <= cur_op_n;
            emit_pend <= pend_n;
            emit_kind <= kind_n;
            emit_val  <= val_n;
            error_q   <= err_n;
            busy_q    <= down_busy;
            stb_q     <= number_stb || sign_stb;
`ifdef SHUNTING_YARD_PAREN_EN
            last_q    <= last_n;
`endif
        end
    end

endmodule

// File: tb/tb_shunting_yard.sv
// Self-checking bench for shunting_yard: a reference model derives the
// expected postfix emissions for each expression, a monitor compares every
// strobe against them and checks strobe spacing against down_busy.
module tb_shunting_yard;

    localparam int DEPTH = 16;
`ifdef SHUNTING_YARD_PAREN_EN
    localparam bit PAREN = 1'b1;
`else
    localparam bit PAREN = 1'b0;
`endif
    localparam logic [7:0] C_ADD = 8'h2B;
    localparam logic [7:0] C_SUB = 8'h2D;
    localparam logic [7:0] C_MUL = 8'h2A;
    localparam logic [7:0] C_DIV = 8'h2F;
    localparam logic [7:0] C_LP  = 8'h28;
    localparam logic [7:0] C_RP  = 8'h29;

    typedef struct packed { logic [7:0] v; logic num; } tok_t;
    typedef struct packed { logic [1:0] kind; logic [7:0] val; } exp_t;  // kind: 1 num, 2 sign, 3 both

    logic       clk, rst;
    logic [7:0] in_token;
    logic       in_is_num, in_last, in_stb, in_ready, down_busy;
    logic [7:0] out_number, out_sign;
    logic       number_stb, sign_stb, error;

    exp_t exp_q[$];
    tok_t toks[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_mode = 0;
    int   hold = 0;
    int   strobes_seen = 0;
    logic prev_stb = 1'b0;
    logic prev_busy = 1'b0;

    shunting_yard #(.STACK_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_token   (in_token),
        .in_is_num  (in_is_num),
        .in_last    (in_last),
        .in_stb     (in_stb),
        .in_ready   (in_ready),
        .down_busy  (down_busy),
        .out_number (out_number),
        .out_sign   (out_sign),
        .number_stb (number_stb),
        .sign_stb   (sign_stb),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] kind, input logic [7:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        return e;
    endfunction

    function automatic int prec_of(input logic [7:0] c);
        if (c == C_MUL || c == C_DIV) return 2;
        if (c == C_ADD || c == C_SUB) return 1;
        return 0;
    endfunction

    // Reference model: textbook shunting-yard over the token list
    task automatic model(output bit err, output int n_send);
        logic [7:0] stk[$];
        logic [7:0] t, c;
        bit last, found;
        err = 1'b0;
        n_send = toks.size();
        for (int i = 0; i < toks.size() && !err; i++) begin
            last = (i == toks.size() - 1);
            c = toks[i].v;
            if (toks[i].num) begin
                exp_q.push_back(mk(2'd1, c));
            end else if (c == C_ADD || c == C_SUB || c == C_MUL || c == C_DIV) begin
                if (last) err = 1'b1;
                else begin
                    while (stk.size() > 0 && prec_of(stk[$]) >= prec_of(c))
                        exp_q.push_back(mk(2'd2, stk.pop_back()));
                    if (stk.size() == DEPTH) err = 1'b1;
                    else stk.push_back(c);
                end
            end else if (PAREN && c == C_LP) begin
                if (last || stk.size() == DEPTH) err = 1'b1;
                else stk.push_back(c);
            end else if (PAREN && c == C_RP) begin
                found = 1'b0;
                while (!found && !err) begin
                    if (stk.size() == 0) err = 1'b1;
                    else begin
                        t = stk.pop_back();
                        if (t == C_LP) found = 1'b1;
                        else exp_q.push_back(mk(2'd2, t));
                    end
                end
            end else begin
                err = 1'b1;
            end
            if (err) n_send = i + 1;
        end
        while (!err && stk.size() > 1) begin
            t = stk.pop_back();
            if (t == C_LP) err = 1'b1;
            else exp_q.push_back(mk(2'd2, t));
        end
        if (!err) begin
            if (stk.size() == 1) begin
                if (stk[0] == C_LP) err = 1'b1;
                else exp_q.push_back(mk(2'd3, stk[0]));
            end else begin
                exp_q.push_back(mk(2'd3, 8'h00));
            end
        end
    endtask

    // Monitor: pops the scoreboard on every strobe and checks spacing
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            prev_stb  = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (number_stb || sign_stb) begin
                strobes_seen++;
                check("strobe_after_strobe", {31'd0, prev_stb}, 32'd0);
                check("strobe_after_busy", {31'd0, prev_busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got num=%0b sign=%0b number=0x%0h sign=0x%0h, expected none",
                             number_stb, sign_stb, out_number, out_sign);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", {30'd0, sign_stb, number_stb}, {30'd0, e.kind});
                    if (e.kind == 2'd1) check("out_number", {24'd0, out_number}, {24'd0, e.val});
                    else check("out_sign", {24'd0, out_sign}, {24'd0, e.val});
                    if (e.kind == 2'd3) check("final_number", {24'd0, out_number}, 32'd0);
                end
            end
            prev_stb  = number_stb || sign_stb;
            prev_busy = down_busy;
        end
    end

    // Downstream busy generator
    initial begin
        down_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (busy_mode)
                1: down_busy = ($urandom_range(0, 2) == 0);
                2: if (strobes_seen >= 1 && hold < 5) begin
                       down_busy = 1'b1;
                       hold++;
                   end else begin
                       down_busy = 1'b0;
                   end
                3: down_busy = 1'b1;
                default: down_busy = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [7:0] v, input logic num, input logic last);
        int k = 0;
        in_token = v;
        in_is_num = num;
        in_last = last;
        in_stb = 1'b1;
        while (!in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("send_accepted_in_time", {31'd0, (k >= 400)}, 32'd0);
        if (k < 400) @(posedge clk);
        #1;
        in_stb = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_stb = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("rst_strobes_low", {30'd0, number_stb, sign_stb}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_error", {31'd0, error}, 32'd0);
        check("post_rst_outputs", {16'd0, out_number, out_sign}, 32'd0);
    endtask

    task automatic run_expr(input string name);
        bit err;
        int n;
        int k = 0;
        model(err, n);
        for (int i = 0; i < n; i++)
            send(toks[i].v, toks[i].num, (i == toks.size() - 1));
        while ((exp_q.size() != 0 || (!err && !in_ready)) && k < 600) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check({name, "_all_emitted"}, exp_q.size(), 32'd0);
        exp_q.delete();
        check({name, "_error"}, {31'd0, error}, {31'd0, err});
        if (err) do_reset();
    endtask

    function automatic void tn(input logic [7:0] v);
        toks.push_back({v, 1'b1});
    endfunction

    function automatic void to(input logic [7:0] c);
        toks.push_back({c, 1'b0});
    endfunction

    task automatic gen_random();
        logic [7:0] ops [4];
        int depth = 0;
        int nops;
        ops[0] = C_ADD; ops[1] = C_SUB; ops[2] = C_MUL; ops[3] = C_DIV;
        toks.delete();
        nops = $urandom_range(0, 6);
        for (int i = 0; i <= nops; i++) begin
            if (PAREN && depth < 4 && i < nops && $urandom_range(0, 3) == 0) begin
                to(C_LP);
                depth++;
            end
            tn(8'($urandom_range(0, 255)));
            if (PAREN && depth > 0 && $urandom_range(0, 2) == 0) begin
                to(C_RP);
                depth--;
            end
            if (i < nops) to(ops[$urandom_range(0, 3)]);
        end
        while (depth > 0) begin
            to(C_RP);
            depth--;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_token = 8'h00;
        in_is_num = 1'b0;
        in_last = 1'b0;
        in_stb = 1'b0;
        do_reset();

        toks.delete(); tn(3); to(C_ADD); tn(4);
        run_expr("add_3_4");

        toks.delete(); tn(2); to(C_ADD); tn(3); to(C_MUL); tn(4);
        run_expr("prec_2_3_4");

        toks.delete(); to(C_LP); tn(1); to(C_ADD); tn(2); to(C_RP); to(C_MUL); tn(3);
        run_expr("paren_expr");

        busy_mode = 2; hold = 0; strobes_seen = 0;
        toks.delete(); tn(8); to(C_SUB); tn(2); to(C_SUB); tn(1);
        run_expr("busy_sub_chain");
        busy_mode = 0;

        toks.delete();
        for (int i = 0; i < DEPTH + 1; i++) to(C_LP);
        run_expr("stack_overflow");

        toks.delete(); tn(5);
        run_expr("single_number");

        toks.delete(); tn(8'h78);
        toks[0].num = 1'b0;
        run_expr("illegal_token");

        toks.delete(); tn(3); to(C_ADD);
        toks[toks.size()-1].num = 1'b0;
        run_expr("last_is_operator");

        toks.delete(); tn(3); to(C_RP);
        run_expr("unmatched_rparen");

        toks.delete(); to(C_LP); tn(3);
        run_expr("unclosed_lparen");

        // Reset while a number emission is stalled by down_busy
        busy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        send(8'd7, 1'b1, 1'b0);
        @(negedge clk);
        check("stalled_no_strobe", {30'd0, number_stb, sign_stb}, 32'd0);
        do_reset();
        busy_mode = 0;
        repeat (10) @(negedge clk);
        toks.delete(); tn(9); to(C_MUL); tn(2);
        run_expr("after_mid_reset");

        busy_mode = 1;
        for (int r = 0; r < 40; r++) begin
            gen_random();
            run_expr("random");
        end
        busy_mode = 0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
